speculative_path_history: RTL and testbench

SPECULATIVE_PATH_HISTORY -- requirements
Module: speculative_path_history

---
 rtl/global_parameters.sv | 14 +
 rtl/path_history_ckpt_buffer.sv | 79 +++++++
 rtl/speculative_path_history.sv | 101 ++++++++++
 tb/tb_speculative_path_history.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/global_parameters.sv
// Global parameter package shared by the path-history slice.
// Provides the default history geometry (entry count, hash width), the
// checkpoint and fold defaults, and a packed type for one full history.
package global_parameters;

  localparam int PATH_HISTORY_NUM_ENTRIES = 4;
  localparam int PATH_HISTORY_HASH_WIDTH  = 4;
  localparam int PATH_HISTORY_CKPT_DEPTH  = 8;
  localparam int PATH_HISTORY_FOLD_WIDTH  = 12;

  // One history snapshot at the default geometry; index 0 is the newest hash.
  typedef logic [PATH_HISTORY_NUM_ENTRIES-1:0][PATH_HISTORY_HASH_WIDTH-1:0] path_history_t;

endpackage

// File: rtl/path_history_ckpt_buffer.sv
// Checkpoint ring buffer for the speculative path history.
// Holds DEPTH history snapshots and tracks the live window with head/tail
// pointers that carry an extra wrap bit, so full and empty stay distinct.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   alloc          request a new checkpoint holding snapshot
//   snapshot       history captured on an accepted allocation
//   retire         free the oldest live checkpoint
//   recover        roll tail back to just past recover_tag
//   recover_tag    checkpoint being restored
//   ready          a slot is free (registered state only)
//   tag            slot the next accepted allocation receives
//   count          number of live checkpoints
//   recover_data   snapshot stored at recover_tag
module path_history_ckpt_buffer #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc,
  input  logic [DATA_WIDTH-1:0]      snapshot,
  input  logic                       retire,
  input  logic                       recover,
  input  logic [$clog2(DEPTH)-1:0]   recover_tag,
  output logic                       ready,
  output logic [$clog2(DEPTH)-1:0]   tag,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DATA_WIDTH-1:0]      recover_data
);

  localparam int TW = $clog2(DEPTH);
  localparam logic [TW:0] FULL = (TW + 1)'(DEPTH);
  localparam logic [TW:0] ONE  = (TW + 1)'(1);

  logic [TW:0]           head;
  logic [TW:0]           tail;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [TW-1:0]         recover_offset;
  logic [TW:0]           recover_tail;
  logic                  do_alloc;
  logic                  do_retire;

  // With a wrap bit on each pointer the plain difference is the occupancy.
  assign count = tail - head;
  assign ready = (count != FULL);
  assign tag   = tail[TW-1:0];

  assign do_alloc  = alloc && ready && !recover && !rst;
  assign do_retire = retire && (count != '0);

  // Rebuild the wrap bit for the new tail by walking forward from head:
  // recover_tag sits recover_offset slots past head, and stays live.
  assign recover_offset = recover_tag - head[TW-1:0];
  assign recover_tail   = head + {1'b0, recover_offset} + ONE;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (do_retire) head <= head + ONE;
      if (recover)        tail <= recover_tail;
      else if (do_alloc)  tail <= tail + ONE;
    end
  end

  // NOTE: the snapshot array has no reset; occupancy is tracked purely by the
  // pointers, so stale contents are never observable and the array can map
  // onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_alloc) mem[tail[TW-1:0]] <= snapshot;
  end

  assign recover_data = mem[recover_tag];

endmodule

// File: rtl/speculative_path_history.sv
// Speculative path history with checkpoint/recover support.
// Keeps a shift register of PC hashes (index 0 newest), snapshots it into a
// checkpoint buffer on request, restores it on misprediction recovery and
// exposes an XOR-folded compression of the whole history.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   update_valid, new_pc_hash         shift a new hash into the history
//   ckpt_alloc, ckpt_ready, ckpt_tag  checkpoint allocation handshake
//   retire_valid                      free the oldest checkpoint
//   recover_valid, recover_tag        restore history from a checkpoint
//   recover_hash_valid, recover_hash  corrected-path hash shifted after restore
//   path_history_out                  current speculative history
//   folded_history_out                XOR fold of path_history_out
//   ckpt_count                        number of live checkpoints
module speculative_path_history
  import global_parameters::*;
#(
  parameter int NUM_ENTRIES = PATH_HISTORY_NUM_ENTRIES,
  parameter int HASH_WIDTH  = PATH_HISTORY_HASH_WIDTH,
  parameter int CKPT_DEPTH  = 8,
  parameter int FOLD_WIDTH  = 12
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  update_valid,
  input  logic [HASH_WIDTH-1:0]                 new_pc_hash,
  input  logic                                  ckpt_alloc,
  output logic                                  ckpt_ready,
  output logic [$clog2(CKPT_DEPTH)-1:0]         ckpt_tag,
  input  logic                                  retire_valid,
  input  logic                                  recover_valid,
  input  logic [$clog2(CKPT_DEPTH)-1:0]         recover_tag,
  input  logic                                  recover_hash_valid,
  input  logic [HASH_WIDTH-1:0]                 recover_hash,
  output logic [NUM_ENTRIES-1:0][HASH_WIDTH-1:0] path_history_out,
  output logic [FOLD_WIDTH-1:0]                 folded_history_out,
  output logic [$clog2(CKPT_DEPTH):0]           ckpt_count
);

  localparam int TOTAL_WIDTH = NUM_ENTRIES * HASH_WIDTH;
  localparam int NUM_CHUNKS  = (TOTAL_WIDTH + FOLD_WIDTH - 1) / FOLD_WIDTH;
  localparam int PAD_WIDTH   = NUM_CHUNKS * FOLD_WIDTH;

  logic [NUM_ENTRIES-1:0][HASH_WIDTH-1:0] history;
  logic [NUM_ENTRIES-1:0][HASH_WIDTH-1:0] history_next;
  logic [NUM_ENTRIES-1:0][HASH_WIDTH-1:0] restored;
  logic [TOTAL_WIDTH-1:0]                 restored_flat;
  logic [PAD_WIDTH-1:0]                   padded;
  logic [FOLD_WIDTH-1:0]                  fold;

  path_history_ckpt_buffer #(
    .DEPTH      (CKPT_DEPTH),
    .DATA_WIDTH (TOTAL_WIDTH)
  ) u_ckpt (
    .clk          (clk),
    .rst          (rst),
    .alloc        (ckpt_alloc),
    .snapshot     (history),
    .retire       (retire_valid),
    .recover      (recover_valid),
    .recover_tag  (recover_tag),
    .ready        (ckpt_ready),
    .tag          (ckpt_tag),
    .count        (ckpt_count),
    .recover_data (restored_flat)
  );

  assign restored = restored_flat;

  // Recovery wins outright: the same-cycle speculative update belongs to the
  // squashed path and is dropped.
  // NOTE: each always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    history_next = history;
    if (recover_valid) begin
      if (recover_hash_valid) history_next = {restored[NUM_ENTRIES-2:0], recover_hash};
      else                    history_next = restored;
    end else if (update_valid) begin
      history_next = {history[NUM_ENTRIES-2:0], new_pc_hash};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) history <= '0;
    else     history <= history_next;
  end

  // Zero-pad the flattened history up to a whole number of chunks, then XOR
  // the chunks together.
  always_comb begin
    padded = '0;
    padded[TOTAL_WIDTH-1:0] = history;
    fold = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) fold ^= padded[i*FOLD_WIDTH +: FOLD_WIDTH];
  end

  assign path_history_out   = history;
  assign folded_history_out = fold;

endmodule

// File: tb/tb_speculative_path_history.sv
// Self-checking bench for speculative_path_history at NUM_ENTRIES=4,
// HASH_WIDTH=4, CKPT_DEPTH=4, FOLD_WIDTH=12. A reference model holds the
// history as a 16-bit value and the live checkpoints as a queue of
// (tag, snapshot) pairs; directed scenarios are followed by random traffic.
module tb_speculative_path_history;
  import global_parameters::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        update_valid;
  logic [3:0]  new_pc_hash;
  logic        ckpt_alloc;
  logic        ckpt_ready;
  logic [1:0]  ckpt_tag;
  logic        retire_valid;
  logic        recover_valid;
  logic [1:0]  recover_tag;
  logic        recover_hash_valid;
  logic [3:0]  recover_hash;
  path_history_t path_history_out;
  logic [11:0] folded_history_out;
  logic [2:0]  ckpt_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          tag;
    logic [15:0] snap;
  } ckpt_t;

  ckpt_t       m_q[$];
  logic [15:0] m_hist;
  int          m_tag;

  speculative_path_history #(
    .NUM_ENTRIES (4),
    .HASH_WIDTH  (4),
    .CKPT_DEPTH  (4),
    .FOLD_WIDTH  (12)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .update_valid       (update_valid),
    .new_pc_hash        (new_pc_hash),
    .ckpt_alloc         (ckpt_alloc),
    .ckpt_ready         (ckpt_ready),
    .ckpt_tag           (ckpt_tag),
    .retire_valid       (retire_valid),
    .recover_valid      (recover_valid),
    .recover_tag        (recover_tag),
    .recover_hash_valid (recover_hash_valid),
    .recover_hash       (recover_hash),
    .path_history_out   (path_history_out),
    .folded_history_out (folded_history_out),
    .ckpt_count         (ckpt_count)
  );

  always #5 clk = ~clk;

  // Bit i of the history lands on fold bit (i mod 12).
  function automatic logic [11:0] model_fold(input logic [15:0] h);
    logic [11:0] f = '0;
    for (int i = 0; i < 16; i++) f[i % 12] ^= h[i];
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", name, observed, expected);
      end
  endtask

  task automatic check_all(input string name);
    check({name, "_hist"},  32'(path_history_out),   32'(m_hist));
    check({name, "_fold"},  32'(folded_history_out), 32'(model_fold(m_hist)));
    check({name, "_count"}, 32'(ckpt_count),         32'(m_q.size()));
    check({name, "_ready"}, 32'(ckpt_ready),         32'(m_q.size() < 4));
    check({name, "_tag"},   32'(ckpt_tag),           32'(m_tag));
  endtask

  // One clock: drive inputs away from the edge, advance the model with the
  // same inputs, then compare every output.
  task automatic step(input string name, input logic r, input logic upd, input logic [3:0] h,
                      input logic al, input logic ret, input logic rec, input logic [1:0] rt,
                      input logic rhv, input logic [3:0] rh);
    int          sz;
    int          idx;
    logic [15:0] snap;
    @(negedge clk);
    rst = r; update_valid = upd; new_pc_hash = h; ckpt_alloc = al;
    retire_valid = ret; recover_valid = rec; recover_tag = rt;
    recover_hash_valid = rhv; recover_hash = rh;
    @(posedge clk);
    #1;
    sz = m_q.size();
    if (r) begin
      m_hist = '0;
      m_q.delete();
      m_tag = 0;
    end else if (rec) begin
      idx = -1;
      foreach (m_q[i]) if (m_q[i].tag == int'(rt)) idx = i;
      if (idx < 0) begin
        $display("FAIL recover_tag_live tag=%0d is outside the live window", rt);
        $fatal(1, "illegal recover_tag in stimulus");
      end
      snap = m_q[idx].snap;
      while (m_q.size() > idx + 1) void'(m_q.pop_back());
      m_hist = rhv ? {snap[11:0], rh} : snap;
      m_tag  = (int'(rt) + 1) % 4;
      if (ret && sz > 0) void'(m_q.pop_front());
    end else begin
      if (al && sz < 4) begin
        m_q.push_back('{tag: m_tag, snap: m_hist});
        m_tag = (m_tag + 1) % 4;
      end
      if (ret && sz > 0) void'(m_q.pop_front());
      if (upd) m_hist = {m_hist[11:0], h};
    end
    check_all(name);
  endtask

  initial begin
    int          idx;
    logic        upd, al, ret, rec, rhv, r;
    logic [1:0]  rt;

    rst = 1'b1; update_valid = 0; new_pc_hash = 0; ckpt_alloc = 0; retire_valid = 0;
    recover_valid = 0; recover_tag = 0; recover_hash_valid = 0; recover_hash = 0;
    m_hist = '0; m_tag = 0;

    // Reset state.
    step("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("reset_hist_const", 32'(path_history_out), 32'h0);
    check("reset_ready_const", 32'(ckpt_ready), 32'h1);

    // Three updates build 0x0123; fold is 0x123.
    step("upd1", 0, 1, 4'h1, 0, 0, 0, 0, 0, 0);
    step("upd2", 0, 1, 4'h2, 0, 0, 0, 0, 0, 0);
    step("upd3", 0, 1, 4'h3, 0, 0, 0, 0, 0, 0);
    check("basic_hist_const", 32'(path_history_out), 32'h0123);
    check("basic_fold_const", 32'(folded_history_out), 32'h123);

    // Checkpoint, run ahead, recover with a corrected hash.
    step("alloc0", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step("upd4", 0, 1, 4'h4, 0, 0, 0, 0, 0, 0);
    step("upd5", 0, 1, 4'h5, 0, 0, 0, 0, 0, 0);
    check("spec_hist_const", 32'(path_history_out), 32'h2345);
    step("recover0", 0, 0, 0, 0, 0, 1, 2'd0, 1, 4'hA);
    check("recover_hist_const", 32'(path_history_out), 32'h123A);
    check("recover_count_const", 32'(ckpt_count), 32'd1);

    // Fill the buffer, overflow alloc is ignored, one retire frees a slot.
    step("fill_reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step("fill", 0, 1, 4'(k + 5), 1, 0, 0, 0, 0, 0);
    check("full_ready_const", 32'(ckpt_ready), 32'h0);
    check("full_tag_const", 32'(ckpt_tag), 32'h0);
    step("overflow", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    check("overflow_count_const", 32'(ckpt_count), 32'd4);
    check("overflow_tag_const", 32'(ckpt_tag), 32'h0);
    step("retire", 0, 0, 0, 0, 1, 0, 0, 0, 0);
    check("retire_ready_const", 32'(ckpt_ready), 32'h1);
    check("retire_count_const", 32'(ckpt_count), 32'd3);

    // Update + alloc + recover together: only the recover lands.
    step("collide", 0, 1, 4'hF, 1, 0, 1, 2'd2, 0, 0);
    check("collide_hist_const", 32'(path_history_out), 32'h0056);
    check("collide_count_const", 32'(ckpt_count), 32'd2);
    check("collide_tag_const", 32'(ckpt_tag), 32'd3);

    // Reset beats a pending recover.
    step("alloc3", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    check("pre_rst_count_const", 32'(ckpt_count), 32'd3);
    step("rst_recover", 1, 1, 4'h9, 1, 1, 1, 2'd1, 1, 4'h7);
    check("rst_hist_const", 32'(path_history_out), 32'h0);
    check("rst_fold_const", 32'(folded_history_out), 32'h0);

    // Six alloc/retire pairs wrap the tag; recover to the wrapped tag.
    for (int k = 0; k < 6; k++) begin
      step("wrap_alloc", 0, 1, 4'(k + 1), 1, 0, 0, 0, 0, 0);
      step("wrap_retire", 0, 0, 0, 0, 1, 0, 0, 0, 0);
    end
    check("wrap_tag_const", 32'(ckpt_tag), 32'd2);
    step("wrap_alloc2", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step("wrap_upd7", 0, 1, 4'h7, 0, 0, 0, 0, 0, 0);
    step("wrap_upd8", 0, 1, 4'h8, 0, 0, 0, 0, 0, 0);
    step("wrap_recover", 0, 0, 0, 0, 0, 1, 2'd2, 0, 0);
    check("wrap_hist_const", 32'(path_history_out), 32'h3456);
    check("wrap_count_const", 32'(ckpt_count), 32'd1);

    // Random traffic; recover tags are always drawn from the live window.
    for (int n = 0; n < 400; n++) begin
      r   = ($urandom_range(0, 63) == 0);
      upd = $urandom_range(0, 1) == 1;
      al  = $urandom_range(0, 9) < 4;
      ret = $urandom_range(0, 9) < 3;
      rhv = $urandom_range(0, 1) == 1;
      rec = 1'b0;
      rt  = 2'($urandom_range(0, 3));
      if (m_q.size() > 0 && $urandom_range(0, 9) < 2) begin
        idx = $urandom_range(0, m_q.size() - 1);
        rec = 1'b1;
        rt  = 2'(m_q[idx].tag);
        if (idx == 0) ret = 1'b0;
      end
      step("rand", r, upd, 4'($urandom), al, ret, rec, rt, rhv, 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
